// File: rtl/uart_rx_os.sv
// Oversampling UART receiver with majority-vote sampling, false-start rejection and a valid/ready output.
// Optional parity checking is compiled in when UART_RX_PARITY_EN is defined.
module uart_rx_os #(
    parameter int CLKS_PER_TICK = 326,
    parameter int OVERSAMPLE    = 16,
    parameter int DATA_BITS     = 8,
`ifdef UART_RX_PARITY_EN
    parameter int PARITY_ODD    = 0,
`endif
    parameter int STOP_BITS     = 1
) (
    input  logic                 sysclk,
    input  logic                 reset,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 parity_err,
    output logic                 busy
);

    localparam int TW  = $clog2(CLKS_PER_TICK);
    localparam int SW  = $clog2(OVERSAMPLE);
    localparam int BW  = 4;
    localparam int MID = OVERSAMPLE / 2;

    localparam logic [TW-1:0] T_LAST     = TW'(CLKS_PER_TICK - 1);
    localparam logic [SW-1:0] S_VOTE0    = SW'(MID - 1);
    localparam logic [SW-1:0] S_VOTE1    = SW'(MID);
    localparam logic [SW-1:0] S_DECIDE   = SW'(MID + 1);
    localparam logic [SW-1:0] S_LAST     = SW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] B_LASTDATA = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] B_LASTSTOP = BW'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        BREAK
    } state_t;

    state_t state, state_next;

    logic                 sync1, rxs;
    logic [TW-1:0]        tick_cnt;
    logic                 tick;
    logic [SW-1:0]        samp_cnt;
    logic [BW-1:0]        bit_cnt;
    logic                 vote0, vote1, maj;
    logic                 decide, bound;
    logic [DATA_BITS-1:0] shift_reg;

    logic start_frame, shift_en, bit_inc, bit_clr, complete, frame_bad;
    logic word_ok, load;

    // Two-flop synchroniser on the asynchronous line
    always_ff @(posedge sysclk) begin
        if (reset) begin
            sync1 <= 1'b1;
            rxs   <= 1'b1;
        end else begin
            sync1 <= rxd;
            rxs   <= sync1;
        end
    end

    // Tick counter restarts on the start edge so samples sit at fixed offsets from it
    always_ff @(posedge sysclk) begin
        if (reset || start_frame || tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + TW'(1);
        end
    end

    assign tick = (tick_cnt == T_LAST);

    always_ff @(posedge sysclk) begin
        if (reset || start_frame) begin
            samp_cnt <= '0;
        end else if (tick) begin
            samp_cnt <= (samp_cnt == S_LAST) ? '0 : samp_cnt + SW'(1);
        end
    end

    assign decide = tick && (samp_cnt == S_DECIDE);
    assign bound  = tick && (samp_cnt == S_LAST);

    // The third vote is the live sample taken on the decision tick itself
    always_ff @(posedge sysclk) begin
        if (tick && (samp_cnt == S_VOTE0)) vote0 <= rxs;
        if (tick && (samp_cnt == S_VOTE1)) vote1 <= rxs;
    end

    assign maj = (vote0 & vote1) | (vote0 & rxs) | (vote1 & rxs);

    always_ff @(posedge sysclk) begin
        if (reset || bit_clr) begin
            bit_cnt <= '0;
        end else if (bit_inc) begin
            bit_cnt <= bit_cnt + BW'(1);
        end
    end

    always_ff @(posedge sysclk) begin
        if (shift_en) shift_reg <= {maj, shift_reg[DATA_BITS-1:1]};
    end

`ifdef UART_RX_PARITY_EN
    logic par_sample, parity_bad;

    always_ff @(posedge sysclk) begin
        if (reset || start_frame) begin
            parity_bad <= 1'b0;
        end else if (par_sample) begin
            parity_bad <= maj ^ (^shift_reg) ^ (PARITY_ODD != 0);
        end
    end

    assign word_ok = complete && !parity_bad;
`else
    assign word_ok = complete;
`endif

    always_ff @(posedge sysclk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        start_frame = 1'b0;
        shift_en    = 1'b0;
        bit_inc     = 1'b0;
        bit_clr     = 1'b0;
        complete    = 1'b0;
        frame_bad   = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_sample  = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (!rxs) begin
                    state_next  = START;
                    start_frame = 1'b1;
                end
            end
            START: begin
                if (decide && maj) begin
                    state_next = IDLE;
                end else if (bound) begin
                    state_next = DATA;
                    bit_clr    = 1'b1;
                end
            end
            DATA: begin
                shift_en = decide;
                if (bound) begin
                    if (bit_cnt == B_LASTDATA) begin
`ifdef UART_RX_PARITY_EN
                        state_next = PARITY;
`else
                        state_next = STOP;
`endif
                        bit_clr = 1'b1;
                    end else begin
                        bit_inc = 1'b1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                par_sample = decide;
                if (bound) state_next = STOP;
            end
`endif
            // A good final stop bit returns to IDLE at its centre so a following start edge is not missed
            STOP: begin
                if (decide) begin
                    if (!maj) begin
                        frame_bad  = 1'b1;
                        state_next = BREAK;
                    end else if (bit_cnt == B_LASTSTOP) begin
                        complete   = 1'b1;
                        state_next = IDLE;
                    end
                end else if (bound) begin
                    bit_inc = 1'b1;
                end
            end
            BREAK: begin
                if (rxs) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign load = word_ok && (!rx_valid || rx_ready);

    always_ff @(posedge sysclk) begin
        if (reset) begin
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= frame_bad;
            overrun   <= word_ok && rx_valid && !rx_ready;
            if (load) begin
                rx_data  <= shift_reg;
                rx_valid <= 1'b1;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge sysclk) begin
        if (reset) begin
            parity_err <= 1'b0;
        end else begin
            parity_err <= complete && parity_bad;
        end
    end
`else
    assign parity_err = 1'b0;
`endif

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_os.sv
// Scoreboard bench for uart_rx_os: expected words are queued as frames are driven and
// compared when the receiver hands them over; flag pulses are counted and checked per scenario.
module tb_uart_rx_os;

    localparam int CPT = 4;
    localparam int OS  = 16;
    localparam int DB  = 8;
    localparam int SB  = 1;
    localparam int BIT = CPT * OS;

    logic          sysclk = 1'b0;
    logic          reset;
    logic          rxd;
    logic [DB-1:0] rx_data;
    logic          rx_valid;
    logic          rx_ready;
    logic          frame_err;
    logic          overrun;
    logic          parity_err;
    logic          busy;

    int n_chk  = 0;
    int n_pass = 0;
    int n_ferr = 0;
    int n_ovr  = 0;
    int n_perr = 0;

    logic [7:0] sb[$];

    uart_rx_os #(
        .CLKS_PER_TICK(CPT),
        .OVERSAMPLE   (OS),
        .DATA_BITS    (DB),
        .STOP_BITS    (SB)
    ) dut (
        .sysclk    (sysclk),
        .reset     (reset),
        .rxd       (rxd),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .frame_err (frame_err),
        .overrun   (overrun),
        .parity_err(parity_err),
        .busy      (busy)
    );

    always #5 sysclk = ~sysclk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Output side: pop and compare on every accepted word, count flag pulses
    always @(negedge sysclk) begin
        logic [31:0] exp_word;
        if (!reset) begin
            if (frame_err)  n_ferr++;
            if (overrun)    n_ovr++;
            if (parity_err) n_perr++;
            if (rx_valid && rx_ready) begin
                exp_word = (sb.size() > 0) ? 32'(sb.pop_front()) : 32'hDEAD;
                check("rx_word", 32'(rx_data), exp_word);
            end
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) begin
            @(posedge sysclk);
            #1;
        end
    endtask

    task automatic drive_bit(input logic b, input int n);
        rxd = b;
        wait_cyc(n);
    endtask

    // spike_bit >= 0 inverts a one-tick slice around the centre of that data bit
    task automatic send_frame(input logic [7:0] d, input logic stop_v, input int stop_n,
                              input logic par_on, input logic par_v, input int spike_bit);
        drive_bit(1'b0, BIT);
        for (int i = 0; i < DB; i++) begin
            if (i == spike_bit) begin
                drive_bit(d[i], 35);
                drive_bit(~d[i], CPT);
                drive_bit(d[i], BIT - 35 - CPT);
            end else begin
                drive_bit(d[i], BIT);
            end
        end
        if (par_on) drive_bit(par_v, BIT);
        drive_bit(stop_v, stop_n);
        rxd = 1'b1;
    endtask

    initial begin
        reset    = 1'b1;
        rxd      = 1'b1;
        rx_ready = 1'b1;
        wait_cyc(4);
        check("rst_valid", 32'(rx_valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_data", 32'(rx_data), 0);
        check("rst_flags", {29'd0, frame_err, overrun, parity_err}, 0);
        reset = 1'b0;
        wait_cyc(20);

        // Single frame, then two back-to-back frames with no idle gap
        sb.push_back(8'hA5);
        send_frame(8'hA5, 1'b1, BIT, 1'b0, 1'b0, -1);
        sb.push_back(8'h00);
        send_frame(8'h00, 1'b1, BIT, 1'b0, 1'b0, -1);
        sb.push_back(8'hFF);
        send_frame(8'hFF, 1'b1, BIT, 1'b0, 1'b0, -1);
        wait_cyc(BIT);
        check("b2b_drain", sb.size(), 0);
        check("b2b_ferr", n_ferr, 0);
        check("b2b_ovr", n_ovr, 0);

        // Short low glitch is a false start
        drive_bit(1'b0, 20);
        rxd = 1'b1;
        check("glitch_busy_hi", 32'(busy), 1);
        wait_cyc(62);
        check("glitch_busy_lo", 32'(busy), 0);
        check("glitch_ferr", n_ferr, 0);

        // Stop bit held low: framing error, then recovery
        send_frame(8'h3C, 1'b0, 200, 1'b0, 1'b0, -1);
        wait_cyc(20);
        check("ferr_count", n_ferr, 1);
        sb.push_back(8'h55);
        send_frame(8'h55, 1'b1, BIT, 1'b0, 1'b0, -1);
        wait_cyc(BIT);
        check("ferr_recover", sb.size(), 0);
        check("ferr_once", n_ferr, 1);

        // One-tick noise spike on bit 3 outvoted
        sb.push_back(8'h00);
        send_frame(8'h00, 1'b1, BIT, 1'b0, 1'b0, 3);
        wait_cyc(BIT);
        check("spike_drain", sb.size(), 0);

        // Reset mid-frame with a word pending
        rx_ready = 1'b0;
        send_frame(8'h81, 1'b1, BIT, 1'b0, 1'b0, -1);
        wait_cyc(BIT);
        check("pre_rst_valid", 32'(rx_valid), 1);
        drive_bit(1'b0, BIT);
        drive_bit(1'b1, BIT);
        drive_bit(1'b0, BIT / 2);
        check("mid_busy", 32'(busy), 1);
        reset = 1'b1;
        rxd   = 1'b1;
        wait_cyc(2);
        check("mid_rst_valid", 32'(rx_valid), 0);
        check("mid_rst_data", 32'(rx_data), 0);
        check("mid_rst_busy", 32'(busy), 0);
        reset    = 1'b0;
        rx_ready = 1'b1;
        wait_cyc(20);
        sb.push_back(8'h81);
        send_frame(8'h81, 1'b1, BIT, 1'b0, 1'b0, -1);
        wait_cyc(BIT);
        check("post_rst_drain", sb.size(), 0);
        check("post_rst_ovr", n_ovr, 0);

        // Overrun: second word dropped while the first is held
        rx_ready = 1'b0;
        sb.push_back(8'h11);
        send_frame(8'h11, 1'b1, BIT, 1'b0, 1'b0, -1);
        send_frame(8'h22, 1'b1, BIT, 1'b0, 1'b0, -1);
        wait_cyc(BIT);
        check("ovr_valid", 32'(rx_valid), 1);
        check("ovr_data", 32'(rx_data), 32'h11);
        check("ovr_count", n_ovr, 1);
        rx_ready = 1'b1;
        wait_cyc(1);
        check("ovr_release", 32'(rx_valid), 0);
        check("ovr_drain", sb.size(), 0);

`ifdef UART_RX_PARITY_EN
        // Even parity: 0x07 has three ones, so the correct parity bit is 1
        sb.push_back(8'h07);
        send_frame(8'h07, 1'b1, BIT, 1'b1, 1'b1, -1);
        send_frame(8'h07, 1'b1, BIT, 1'b1, 1'b0, -1);
        wait_cyc(BIT);
        check("par_drain", sb.size(), 0);
        check("par_err_count", n_perr, 1);
        check("par_ferr", n_ferr, 1);
`else
        check("no_par_err", n_perr, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/uart_rx_os.md
Name: uart_rx_os

Overview:
- Parametrised oversampling UART receiver; successor to the fixed 8N1 / 16x receiver.
- Runs entirely on sysclk using an internal tick enable, not a derived clock.
- Generalised in tick divider, oversample ratio, data width and stop-bit count; adds majority-vote sampling, false-start rejection, framing/overrun detection and a valid/ready output handshake.
- Sits between the board rxd pin and the controller/FIFO.

Parameters:
- CLKS_PER_TICK, 326: sysclk cycles per oversample tick (50 MHz / (16 x 9600)). Legal range 2..65535.
- OVERSAMPLE, 16: ticks per bit. Must be even, 8..64.
- DATA_BITS, 8: data bits per frame, 5..9, LSB first.
- STOP_BITS, 1: stop bits checked, 1 or 2.

Ports:
- sysclk, in, 1: clock.
- reset, in, 1: synchronous, active-high reset.
- rxd, in, 1: asynchronous serial line, idle high.
- rx_data, out, DATA_BITS: received word; stable while rx_valid=1.
- rx_valid, out, 1: word available; held until accepted.
- rx_ready, in, 1: consumer accepts the word when rx_valid && rx_ready on a sysclk edge.
- frame_err, out, 1: one-cycle pulse on a bad stop bit.
- overrun, out, 1: one-cycle pulse when a completed word is dropped.
- parity_err, out, 1: one-cycle pulse on parity mismatch; tied 0 when the optional feature is out.
- busy, out, 1: high in any state other than IDLE.

Behaviour:
- Reset: sync flops = 1; tick counter, sample counter and bit counter = 0; state = IDLE; rx_data = 0; rx_valid, frame_err, overrun, parity_err, busy = 0. Reset mid-frame aborts the frame with no flags.
- Input: rxd passes through a 2-flop synchroniser (reset value 1); rxs is the second flop.
- Tick: counter runs 0..CLKS_PER_TICK-1 and pulses tick for one cycle at the top. The counter is forced to 0 on the IDLE->START transition so sampling is phase-aligned to the falling edge.
- Sample counter: advances 0..OVERSAMPLE-1 on each tick and wraps at the bit boundary.
- Majority vote: the line is sampled at sample counts M-1, M and M+1, where M = OVERSAMPLE/2. The bit value is the 2-of-3 majority, decided on the tick at M+1.
- IDLE: when rxs = 0, go to START and clear the counters.
- START: at the decision point, majority = 1 is a false start -> IDLE with no flags; majority = 0 -> DATA at the bit boundary.
- DATA: DATA_BITS bits shifted into the shift register LSB first. After the last bit -> PARITY if the feature is in, else STOP.
- STOP: STOP_BITS bits are checked, each at its decision point.
  - Any stop majority = 0: pulse frame_err, discard the word, go to BREAK.
  - All stop bits = 1: complete the word and go to IDLE immediately at the decision point, not at the bit end, to allow resync on a back-to-back start.
- BREAK: wait until rxs = 1, then IDLE.
- Word completion (same edge as the final stop decision):
  - rx_valid = 0, or rx_ready = 1 on that edge: load rx_data and set rx_valid = 1.
  - rx_valid = 1 and rx_ready = 0: keep the old rx_data, pulse overrun, rx_valid stays 1.
  - Latency: rx_valid rises 1 sysclk after the final stop-bit decision tick.
- Handshake: rx_valid && rx_ready with no completion on the same edge -> rx_valid = 0 next cycle.
- Flags: frame_err and parity_err never occur with a load. A parity error discards the word (no rx_valid).
- busy = (state != IDLE).

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined: adds parameter PARITY_ODD (default 0 = even). After the data bits, the PARITY state samples one bit by majority. The parity bit is checked against the XOR of the data bits, inverted when PARITY_ODD = 1.
  - Mismatch: latch the error, still check the stop bits, then pulse parity_err at the stop decision with no load. A bad stop bit pulses frame_err only.
- Undefined: no PARITY state, frame = start + data + stop, parity_err tied 0.

Test Plan:
All cases use CLKS_PER_TICK = 4, OVERSAMPLE = 16 (bit = 64 cycles), DATA_BITS = 8, STOP_BITS = 1, rx_ready = 1 unless stated.
- Frame 0xA5 8N1 -> exactly one rx_valid with rx_data = 0xA5; no flags. Then back-to-back frames 0x00 and 0xFF with zero idle gap -> both received in order.
- Low glitch of 20 cycles on an idle line -> START rejected, no rx_valid, busy returns to 0 within 64 cycles.
- Frame 0x3C with stop bit driven 0 for 200 cycles -> frame_err pulses once, no rx_valid; after rxd returns high, a 0x55 frame is received correctly.
- rx_ready = 0, send 0x11 then 0x22 -> rx_data stays 0x11 with rx_valid = 1, overrun pulses once. Raise rx_ready -> rx_valid drops the next cycle.
- Single-tick noise spike (4 cycles) inverted at the centre of bit 3 of 0x00 -> rx_data = 0x00 (majority vote holds). Reset asserted mid-data -> all outputs at reset values; the next frame 0x81 is received correctly.
- With UART_RX_PARITY_EN, even parity: 0x07 with parity bit 1 -> rx_data = 0x07; 0x07 with parity bit 0 -> parity_err pulse, no rx_valid.
